// File: rtl/qvga_pkg.sv
// Shared types and constants for the QVGA camera capture path and frame buffer.
package qvga_pkg;

    localparam int QVGA_H    = 320;
    localparam int QVGA_V    = 240;
    localparam int FB_ADDR_W = 17;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } cap_state_t;

    // Keep the top bits of each RGB565 channel (R5->R4, G6->G4, B5->B4).
    function automatic rgb444_t rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        rgb444_t p;
        p.r = hi[7:4];
        p.g = {hi[2:0], lo[7]};
        p.b = lo[4:1];
        return p;
    endfunction

endpackage

// File: rtl/qvga_cam_capture_if.sv
// Camera pin group and frame-buffer write port; master is the camera/memory side, slave the capture block.
interface qvga_cam_capture_if import qvga_pkg::*; #(parameter int ADDR_W = FB_ADDR_W);

    logic              vsync;
    logic              href;
    logic [7:0]        cam_data;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [11:0]       wData;

    modport master (output vsync, output href, output cam_data,
                    input  we,    input  wAddr, input  wData);

    modport slave  (input  vsync, input  href,  input  cam_data,
                    output we,    output wAddr, output wData);

endinterface

// File: rtl/cam_byte_pair.sv
// Pairs consecutive camera bytes into one RGB565 pixel and repacks it as RGB444.
module cam_byte_pair import qvga_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       sample,
    input  logic [7:0] cam_data,
    output logic       pix_valid,
    output rgb444_t    pix
);

    logic       phase_r;
    logic [7:0] hi_r;

    // Byte phase toggles per sampled byte; the first byte of each pair is held as the hi byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= 1'b0;
            hi_r    <= 8'h00;
        end else if (clear) begin
            phase_r <= 1'b0;
        end else if (sample) begin
            if (!phase_r) begin
                hi_r <= cam_data;
            end
            phase_r <= ~phase_r;
        end
    end

    // The lo byte is consumed straight off the pins so the write lands one cycle after it.
    assign pix_valid = sample & phase_r;
    assign pix       = rgb565_to_444(hi_r, cam_data);

endmodule

// File: rtl/qvga_cam_capture.sv
// Captures an 8-bit RGB565 camera stream into a QVGA RGB444 frame buffer at y*H_PIX+x.
module qvga_cam_capture import qvga_pkg::*; #(
    parameter int H_PIX   = QVGA_H,
    parameter int V_LINES = QVGA_V,
    parameter int ADDR_W  = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    qvga_cam_capture_if.slave bus,
    output logic              frame_active,
    output logic              frame_done
);

    localparam logic [9:0]        H_LIM  = 10'(H_PIX);
    localparam logic [8:0]        V_LIM  = 9'(V_LINES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIX);

    cap_state_t        state_r;
    logic [9:0]        x_r;
    logic [8:0]        y_r;
    logic [ADDR_W-1:0] line_base_r;
    logic              vsync_d_r;
    logic              href_d_r;

    logic              vs_fall_s;
    logic              vs_rise_s;
    logic              href_fall_s;
    logic              sample_s;
    logic              clear_s;
    logic              pix_valid_s;
    rgb444_t           pix_s;

    assign vs_fall_s   = vsync_d_r & ~bus.vsync;
    assign vs_rise_s   = ~vsync_d_r & bus.vsync;
    assign href_fall_s = href_d_r & ~bus.href;
    assign sample_s    = (state_r == ACTIVE) & bus.href;
    // Outside a frame and at every line end the pairing restarts on a hi byte.
    assign clear_s     = (state_r != ACTIVE) | href_fall_s;

    cam_byte_pair u_byte_pair (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .sample    (sample_s),
        .cam_data  (bus.cam_data),
        .pix_valid (pix_valid_s),
        .pix       (pix_s)
    );

    // Capture FSM with line/pixel counters and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            x_r          <= 10'd0;
            y_r          <= 9'd0;
            line_base_r  <= '0;
            vsync_d_r    <= 1'b0;
            href_d_r     <= 1'b0;
            bus.we       <= 1'b0;
            bus.wAddr    <= '0;
            bus.wData    <= 12'h000;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            vsync_d_r  <= bus.vsync;
            href_d_r   <= bus.href;
            bus.we     <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (capture_en) begin
                        state_r <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (!capture_en) begin
                        state_r <= IDLE;
                    end else if (vs_fall_s) begin
                        state_r      <= ACTIVE;
                        frame_active <= 1'b1;
                        x_r          <= 10'd0;
                        y_r          <= 9'd0;
                        line_base_r  <= '0;
                    end
                end
                ACTIVE: begin
                    // Pixels outside the active window are dropped; x saturates at H_PIX.
                    if (pix_valid_s && (x_r < H_LIM) && (y_r < V_LIM)) begin
                        bus.we    <= 1'b1;
                        bus.wAddr <= line_base_r + ADDR_W'(x_r);
                        bus.wData <= pix_s;
                        x_r       <= x_r + 10'd1;
                    end
                    if (href_fall_s) begin
                        x_r <= 10'd0;
                        if ((x_r != 10'd0) && (y_r < V_LIM)) begin
                            y_r         <= y_r + 9'd1;
                            line_base_r <= line_base_r + H_STEP;
                        end
                    end
                    if (vs_rise_s) begin
                        frame_done   <= 1'b1;
                        frame_active <= 1'b0;
                        state_r      <= capture_en ? WAIT_VS : IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qvga_cam_capture.sv
// Randomized camera-stream bench with a frame-level write model and a per-cycle compare process.
module tb_qvga_cam_capture;

    localparam int H = 320;
    localparam int V = 240;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int cyc;  bit val; }           ev_t;

    logic clk = 1'b0;
    logic reset;
    logic capture_en;
    logic frame_active;
    logic frame_done;

    qvga_cam_capture_if cam_bus ();

    qvga_cam_capture dut (
        .clk          (clk),
        .reset        (reset),
        .capture_en   (capture_en),
        .bus          (cam_bus),
        .frame_active (frame_active),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state, owned by the stimulus process.
    wr_t         exp_wq[$];
    int          fd_q[$];
    ev_t         ev_q[$];
    int          rchk_q[$];
    logic [15:0] line_pix[$];
    bit          captured = 1'b0;
    int          my_y     = 0;
    bit          finish_req = 1'b0;

    // Counters, owned by the compare process.
    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    int n_fd     = 0;
    int max_addr = -1;
    int n_oob    = 0;
    bit exp_active = 1'b0;

    function automatic int conv565(input int p);
        int r5, g6, b5;
        r5 = (p >> 11) & 31;
        g6 = (p >> 5) & 63;
        b5 = p & 31;
        return ((r5 / 2) << 8) | ((g6 / 4) << 4) | (b5 / 2);
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n);
        line_pix.delete();
        for (int i = 0; i < n; i++) line_pix.push_back(16'($urandom));
    endtask

    task automatic end_model();
        if (captured) begin
            fd_q.push_back(cyc + 1);
            ev_q.push_back('{cyc + 1, 1'b0});
        end
        captured = 1'b0;
    endtask

    task automatic begin_frame();
        cam_bus.vsync = 1'b0;
        captured = capture_en;
        if (captured) ev_q.push_back('{cyc + 1, 1'b1});
        my_y = 0;
        repeat (3) tick();
    endtask

    task automatic end_frame();
        cam_bus.vsync = 1'b1;
        end_model();
        repeat (4) tick();
    endtask

    task automatic send_line(input int nbytes, input bit vs_end);
        int          px;
        logic [15:0] p;
        for (int b = 0; b < nbytes; b++) begin
            p = line_pix[b / 2];
            cam_bus.href     = 1'b1;
            cam_bus.cam_data = (b % 2 == 0) ? p[15:8] : p[7:0];
            if (b % 2 == 1) begin
                px = b / 2;
                if (captured && my_y < V && px < H)
                    exp_wq.push_back('{my_y * H + px, conv565(int'(p)), cyc + 1});
            end
            if (vs_end && b == nbytes - 1) begin
                cam_bus.vsync = 1'b1;
                end_model();
            end
            tick();
        end
        cam_bus.href = 1'b0;
        tick();
        if (captured && nbytes >= 2 && my_y < V) my_y++;
        repeat (3) tick();
    endtask

    // Stimulus and model bookkeeping.
    initial begin
        reset            = 1'b1;
        capture_en       = 1'b0;
        cam_bus.vsync    = 1'b1;
        cam_bus.href     = 1'b0;
        cam_bus.cam_data = 8'h00;
        tick();
        rchk_q.push_back(cyc + 1);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        capture_en = 1'b1;
        repeat (3) tick();

        // Frame A: full height, x/y saturation, odd-length lines.
        begin_frame();
        line_pix.delete();
        line_pix.push_back(16'hF800);
        line_pix.push_back(16'hF800);
        send_line(4, 1'b0);
        fill(330);  send_line(660, 1'b0);
        fill(6);    line_pix[5] = 16'h07E0;  send_line(12, 1'b0);
        fill(1);    send_line(1, 1'b0);
        fill(2);    send_line(3, 1'b0);
        while (my_y < V - 1) begin
            int n;
            n = $urandom_range(1, 3);
            fill(n);
            send_line(2 * n, 1'b0);
        end
        fill(330);  send_line(660, 1'b0);
        repeat (5) begin fill(4); send_line(8, 1'b0); end
        end_frame();

        // Frame B: capture_en drops mid-frame, frame still completes.
        begin_frame();
        for (int l = 0; l < 5; l++) begin
            fill(8); send_line(16, 1'b0);
            if (l == 2) capture_en = 1'b0;
        end
        end_frame();

        // Frame C: capture_en raised mid-frame, nothing captured yet.
        begin_frame();
        for (int l = 0; l < 4; l++) begin
            fill(8); send_line(16, 1'b0);
            if (l == 1) capture_en = 1'b1;
        end
        end_frame();

        // Frame D: odd byte counts.
        begin_frame();
        fill(4); send_line(7, 1'b0);
        fill(3); send_line(5, 1'b0);
        fill(5); send_line(9, 1'b0);
        end_frame();

        // Frame E: reset after pixel 1000, no frame_done.
        begin_frame();
        repeat (10) begin fill(100); send_line(200, 1'b0); end
        reset = 1'b1;
        ev_q.push_back('{cyc + 1, 1'b0});
        rchk_q.push_back(cyc + 1);
        captured = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        repeat (2) begin fill(50); send_line(100, 1'b0); end
        end_frame();

        // Frame F: vsync rises together with the last lo byte.
        begin_frame();
        fill(4); send_line(8, 1'b0);
        fill(3); send_line(6, 1'b1);
        repeat (6) tick();
        finish_req = 1'b1;
    end

    // Per-cycle comparison against the model, then the closing checks.
    always @(negedge clk) begin
        while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
            exp_active = ev_q[0].val;
            void'(ev_q.pop_front());
        end
        check(frame_active === exp_active, "frame_active", int'(frame_active), int'(exp_active));

        while (exp_wq.size() > 0 && exp_wq[0].cyc < cyc) begin
            check(1'b0 == 1'b1 && exp_wq.size() == 0, "missed_write_addr", -1, exp_wq[0].addr);
            void'(exp_wq.pop_front());
        end
        if (cam_bus.we === 1'b1) begin
            check(exp_wq.size() > 0, "unexpected_write", int'(cam_bus.wAddr), -1);
            if (exp_wq.size() > 0) begin
                check(exp_wq[0].cyc == cyc, "write_cycle", cyc, exp_wq[0].cyc);
                check(int'(cam_bus.wAddr) == exp_wq[0].addr, "wAddr", int'(cam_bus.wAddr), exp_wq[0].addr);
                check(int'(cam_bus.wData) == exp_wq[0].data, "wData", int'(cam_bus.wData), exp_wq[0].data);
                void'(exp_wq.pop_front());
            end
            if (n_writes == 0) begin
                check(int'(cam_bus.wAddr) == 0, "first_addr", int'(cam_bus.wAddr), 0);
                check(cam_bus.wData == 12'hF00, "first_red", int'(cam_bus.wData), 12'hF00);
            end
            if (n_writes == 327) begin
                check(int'(cam_bus.wAddr) == 645, "pair_addr", int'(cam_bus.wAddr), 645);
                check(cam_bus.wData == 12'h0F0, "pair_green", int'(cam_bus.wData), 12'h0F0);
            end
            if (int'(cam_bus.wAddr) > max_addr) max_addr = int'(cam_bus.wAddr);
            if (int'(cam_bus.wAddr) > H * V - 1) n_oob++;
            n_writes++;
        end

        while (fd_q.size() > 0 && fd_q[0] < cyc) begin
            check(fd_q.size() == 0, "missed_frame_done", 0, fd_q[0]);
            void'(fd_q.pop_front());
        end
        if (frame_done === 1'b1) begin
            check(fd_q.size() > 0 && fd_q[0] == cyc, "frame_done_cycle", cyc,
                  (fd_q.size() > 0) ? fd_q[0] : -1);
            if (fd_q.size() > 0) void'(fd_q.pop_front());
            n_fd++;
        end

        if (rchk_q.size() > 0 && rchk_q[0] == cyc) begin
            void'(rchk_q.pop_front());
            check(cam_bus.we == 1'b0,      "reset_we",           int'(cam_bus.we), 0);
            check(cam_bus.wAddr == 17'd0,  "reset_wAddr",        int'(cam_bus.wAddr), 0);
            check(cam_bus.wData == 12'h000, "reset_wData",       int'(cam_bus.wData), 0);
            check(frame_active == 1'b0,    "reset_frame_active", int'(frame_active), 0);
            check(frame_done == 1'b0,      "reset_frame_done",   int'(frame_done), 0);
        end

        if (finish_req) begin
            check(exp_wq.size() == 0, "pending_writes", exp_wq.size(), 0);
            check(fd_q.size() == 0,   "pending_frame_done", fd_q.size(), 0);
            check(n_fd == 4,          "frame_done_count", n_fd, 4);
            check(max_addr == 76799,  "max_addr", max_addr, 76799);
            check(n_oob == 0,         "out_of_range_writes", n_oob, 0);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    // Hard time limit in case the stimulus never completes.
    initial begin
        #500000;
        $display("FAIL timeout: got no completion, expected finish before 500000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qvga_cam_capture.md
Name: qvga_cam_capture

Overview:
- Write-side counterpart of the QVGA frame buffer. Captures an OV7670-style 8-bit parallel camera stream (RGB565, two bytes per pixel, QVGA 320x240 mode).
- Converts each pixel to RGB444 and writes it into the 320x240x12 frame buffer at address y*320+x. The display-side reader scans the same buffer.
- Sits between the camera pins, already in the clk domain, and the frame-buffer write port.

Parameters:
H_PIX, 320, active pixels per line written to memory
V_LINES, 240, active lines per frame written to memory
ADDR_W, 17, frame-buffer address width (must hold H_PIX*V_LINES-1)

Ports:
clk  in  1  single clock; camera signals are synchronous to it
reset  in  1  synchronous, active-high reset
capture_en  in  1  level; enables capture starting at next frame boundary
vsync  in  1  camera VSYNC, high = vertical blank
href  in  1  camera HREF, high = valid bytes on cam_data
cam_data  in  8  camera pixel byte
we  out  1  frame-buffer write enable, one cycle per pixel
wAddr  out  ADDR_W  frame-buffer write address
wData  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}
frame_active  out  1  high while a frame is being captured
frame_done  out  1  one-cycle pulse at end of a captured frame

Behaviour:
- Reset: we=0, wAddr=0, wData=0, frame_active=0, frame_done=0. State=IDLE; x, y, line_base, byte phase and vsync_d/href_d history all cleared.
- Edge detection: vsync_d and href_d are registered copies. vs_fall = vsync_d & ~vsync. vs_rise = ~vsync_d & vsync. href_fall = href_d & ~href.
- State IDLE: go to WAIT_VS when capture_en=1.
- State WAIT_VS: on vs_fall go to ACTIVE, frame_active=1, x=y=0, line_base=0, phase=0. If capture_en drops before vs_fall, return to IDLE.
- State ACTIVE, href=1:
  - phase 0: latch cam_data as hi byte; phase<=1.
  - phase 1: form pixel from hi byte and cam_data (lo); phase<=0.
  - If x<H_PIX and y<V_LINES: register we=1, wAddr=line_base+x, wData={hi[7:4], hi[2:0],lo[7], lo[4:1]}, then x<=x+1.
  - Otherwise drop the pixel: no write, x saturates.
- Latency: we/wAddr/wData are valid exactly 1 cycle after the second byte is sampled. we is 0 in every other cycle.
- href_fall in ACTIVE: phase<=0, x<=0. If x>0 and y<V_LINES: y<=y+1 and line_base<=line_base+H_PIX. A line with zero pixels does not advance y.
- Odd byte count at href_fall: dangling hi byte discarded, no write.
- Lines beyond V_LINES and pixels beyond H_PIX are ignored. Short lines/frames leave unwritten locations unchanged.
- vs_rise in ACTIVE: frame_done=1 for one cycle, frame_active=0. Next state is WAIT_VS if capture_en=1, else IDLE.
- capture_en deasserted mid-frame: the current frame completes normally and frame_done still pulses.
- vsync rising while href=1: vs_rise takes priority. The pixel in flight is written if complete; the frame then ends.
- Reset mid-frame: immediate return to reset values, no frame_done.
- Arithmetic: address is formed incrementally (line_base + x); no multiplier. x is 10 bits, y 9 bits, line_base ADDR_W bits. Max address written is H_PIX*V_LINES-1 = 76799.

Decomposition:
- Shared package qvga_pkg:
  - constants QVGA_H=320, QVGA_V=240, FB_ADDR_W=17
  - typedef rgb444_t (12-bit packed struct r/g/b)
  - capture state enum {IDLE, WAIT_VS, ACTIVE}
  - function rgb565_to_444
- One natural sub-module, cam_byte_pair: byte phase, hi-byte latch, RGB565->444 packing. Emits a pixel-valid strobe to the top.
- Counters and FSM stay in the top.

Test Plan:
- Reset, then capture_en=1, one full 320x240 frame with pixel (x,y)=0xF800 (red) -> exactly 76800 writes, wData=0xF00, addresses 0..76799 in order, one frame_done pulse at vs_rise.
- Byte pair hi=0x07, lo=0xE0 at x=5, y=2 -> we one cycle after lo, wAddr=645, wData=0x0F0.
- Line of 330 pixels and frame of 245 lines -> writes stop at x=319 and y=239, no address >76799, next line starts at line_base+320.
- capture_en raised mid-frame -> no writes until after the next vs_fall. capture_en dropped mid-frame -> frame completes, frame_done pulses, FSM returns to IDLE.
- href falls after 3 bytes (odd count) -> exactly 1 write, next line begins at phase 0 with x=0, y incremented.
- reset asserted at pixel 1000 of a frame -> next cycle we=0, wAddr=0, frame_active=0, and no frame_done that frame.
